// File: rtl/isa_cycle_arbiter_if.sv
// isa_cycle_arbiter_if: requester and bus-cycle engine signals of the ISA cycle arbiter
interface isa_cycle_arbiter_if #(parameter int ADDR_W = 10);
  logic req0;
  logic req1;
  logic rw0;
  logic rw1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic ack0;
  logic ack1;
  logic [7:0] rdata;
  logic err;
  logic [7:0] eng_ctrl;
  logic [ADDR_W-1:0] eng_addr;
  logic [7:0] eng_wdata;
  logic [7:0] eng_rdata;
  logic eng_address_load;
  logic eng_data_load;
  logic eng_control_reset;
  modport slave (
    input req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    input eng_rdata, eng_address_load, eng_data_load, eng_control_reset,
    output ack0, ack1, rdata, err, eng_ctrl, eng_addr, eng_wdata
  );
  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    output eng_rdata, eng_address_load, eng_data_load, eng_control_reset,
    input ack0, ack1, rdata, err, eng_ctrl, eng_addr, eng_wdata
  );
endinterface

// File: rtl/isa_cycle_arbiter.sv
// isa_cycle_arbiter: round-robin sharing of the ISA bus-cycle engine between two requesters; ARB_TIMEOUT_EN adds an abort watchdog
module isa_cycle_arbiter #(
  parameter int ADDR_W = 10
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 32
`endif
) (
  input logic clk,
  input logic reset,
  isa_cycle_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  state_t state_nx;
  logic last_grant;
  logic gnt;
  logic dir_rd;
  logic take;
  logic sel;
  logic fin;
  logic abort;
  logic tmo;
  logic rw_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [7:0] wdata_sel;
  assign rw_sel = sel ? bus.rw1 : bus.rw0;
  assign addr_sel = sel ? bus.addr1 : bus.addr0;
  assign wdata_sel = sel ? bus.wdata1 : bus.wdata0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    take = 1'b0;
    fin = 1'b0;
    abort = 1'b0;
    sel = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
    case (state)
      IDLE: begin
        take = bus.req0 | bus.req1;
        state_nx = take ? ISSUE : IDLE;
      end
      ISSUE: begin
        abort = tmo;
        state_nx = tmo ? DONE : (!bus.eng_address_load ? WAIT : ISSUE);
      end
      WAIT: begin
        fin = !bus.eng_control_reset;
        abort = tmo & bus.eng_control_reset;
        state_nx = (fin | abort) ? DONE : WAIT;
      end
      default: state_nx = IDLE;
    endcase
  end
  // eng_ctrl drops on the edge leaving ISSUE; the engine has already latched the request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      gnt <= 1'b0;
      dir_rd <= 1'b0;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.rdata <= 8'h00;
      bus.eng_ctrl <= 8'h00;
      bus.eng_addr <= '0;
      bus.eng_wdata <= 8'h00;
    end else begin
      if (take) begin
        last_grant <= sel;
        gnt <= sel;
        dir_rd <= rw_sel;
        bus.eng_addr <= addr_sel;
        bus.eng_wdata <= wdata_sel;
      end
      bus.eng_ctrl <= take ? {6'b0, ~rw_sel, rw_sel} : (state_nx == ISSUE ? bus.eng_ctrl : 8'h00);
      bus.ack0 <= (fin | abort) & ~gnt;
      bus.ack1 <= (fin | abort) & gnt;
      if (state == WAIT && dir_rd && !bus.eng_data_load && !abort) bus.rdata <= bus.eng_rdata;
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] tcnt;
  assign tmo = (state == ISSUE || state == WAIT) && tcnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= 8'd0;
      bus.err <= 1'b0;
    end else begin
      tcnt <= take ? 8'd0 : ((state == ISSUE || state == WAIT) ? tcnt + 8'd1 : tcnt);
      bus.err <= abort ? 1'b1 : (take ? 1'b0 : bus.err);
    end
  end
`else
  assign tmo = 1'b0;
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_isa_cycle_arbiter.sv
// tb_isa_cycle_arbiter: scoreboard bench with a cycle-level bus-cycle engine model
module tb_isa_cycle_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  isa_cycle_arbiter_if #(.ADDR_W(10)) bus();
  isa_cycle_arbiter #(.ADDR_W(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic p;
    logic [7:0] rd;
    logic e;
  } exp_t;
  exp_t q[$];
  int ack_cyc[$];
  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int rem0 = 0;
  int rem1 = 0;
  logic [7:0] rd_val = 8'h00;
  logic [7:0] model_rdata = 8'h00;
  logic stuck = 1'b0;
  logic [2:0] ecnt;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  // engine: ADDRESS_LOAD one cycle after seeing a request, DATA_LOAD at step 5, CONTROL_RESET at step 7
  always @(posedge clk or negedge reset) begin
    if (!reset) ecnt <= 3'd0;
    else if (ecnt != 3'd0) ecnt <= (ecnt == 3'd7) ? 3'd0 : ecnt + 3'd1;
    else if (bus.eng_ctrl[1:0] != 2'b00) ecnt <= 3'd1;
  end
  assign bus.eng_address_load = !(ecnt == 3'd1);
  assign bus.eng_data_load = !(ecnt == 3'd5 && !stuck);
  assign bus.eng_control_reset = !(ecnt == 3'd7 && !stuck);
  assign bus.eng_rdata = (ecnt == 3'd5) ? rd_val : 8'h00;
  task automatic push(input logic p, input logic is_rd, input logic er);
    exp_t e;
    if (is_rd && !er) model_rdata = rd_val;
    e.p = p;
    e.rd = model_rdata;
    e.e = er;
    q.push_back(e);
  endtask
  task automatic raise(input logic p, input logic rw, input logic [9:0] a, input logic [7:0] wd, output int t0);
    @(posedge clk);
    #1;
    if (p) begin
      bus.rw1 = rw;
      bus.addr1 = a;
      bus.wdata1 = wd;
      bus.req1 = 1'b1;
    end else begin
      bus.rw0 = rw;
      bus.addr0 = a;
      bus.wdata0 = wd;
      bus.req0 = 1'b1;
    end
    t0 = cyc_n;
  endtask
  task automatic serve(input int n, input int budget);
    int got = 0;
    int c = 0;
    logic d0, d1;
    logic re0 = 1'b0;
    logic re1 = 1'b0;
    exp_t e;
    while (got < n && c < budget) begin
      @(negedge clk);
      c++;
      d0 = bus.ack0;
      d1 = bus.ack1;
      if (d0 | d1) begin
        got++;
        ack_cyc.push_back(cyc_n);
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected ack1ack0=%b%b with empty scoreboard", d1, d0);
        end else begin
          e = q.pop_front();
          if ({d1, d0} !== (e.p ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL ack_port ack1ack0=%b%b expected port %0d only", d1, d0, e.p);
          end
          checks++;
          if (bus.rdata !== e.rd) begin
            errors++;
            $display("FAIL rdata got=%h expected=%h", bus.rdata, e.rd);
          end
          checks++;
          if (bus.err !== e.e) begin
            errors++;
            $display("FAIL err got=%b expected=%b", bus.err, e.e);
          end
        end
      end
      @(posedge clk);
      #1;
      if (re0) begin bus.req0 = 1'b1; rem0--; re0 = 1'b0; end
      if (re1) begin bus.req1 = 1'b1; rem1--; re1 = 1'b0; end
      if (d0) begin bus.req0 = 1'b0; re0 = rem0 > 0; end
      if (d1) begin bus.req1 = 1'b0; re1 = rem1 > 0; end
    end
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL serve_timeout acks=%0d expected=%0d", got, n);
    end
  endtask
  task automatic do_reset();
    reset = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    stuck = 1'b0;
    q.delete();
    model_rdata = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.rw0 = 1'b0;
    bus.rw1 = 1'b0;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ack0, bus.ack1, bus.err, bus.eng_ctrl, bus.rdata, bus.eng_addr, bus.eng_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_values ack=%b%b err=%b ctrl=%h rdata=%h addr=%h wdata=%h expected all zero",
               bus.ack1, bus.ack0, bus.err, bus.eng_ctrl, bus.rdata, bus.eng_addr, bus.eng_wdata);
    end
    reset = 1'b1;
  endtask
  task automatic test_read();
    int t0;
    rd_val = 8'hAA;
    push(1'b0, 1'b1, 1'b0);
    raise(1'b0, 1'b1, 10'h22C, 8'h00, t0);
    @(negedge clk);
    checks++;
    if (bus.eng_ctrl !== 8'h00) begin errors++; $display("FAIL read_ctrl_pregrant got=%h expected=00", bus.eng_ctrl); end
    @(negedge clk);
    checks++;
    if (bus.eng_ctrl !== 8'h01 || bus.eng_addr !== 10'h22C) begin
      errors++;
      $display("FAIL read_issue ctrl=%h addr=%h expected ctrl=01 addr=22c", bus.eng_ctrl, bus.eng_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.eng_ctrl !== 8'h01) begin errors++; $display("FAIL read_ctrl_2nd got=%h expected=01", bus.eng_ctrl); end
    @(negedge clk);
    checks++;
    if (bus.eng_ctrl !== 8'h00) begin errors++; $display("FAIL read_ctrl_clear got=%h expected=00", bus.eng_ctrl); end
    serve(1, 40);
    checks++;
    if (ack_cyc[ack_cyc.size() - 1] - t0 != 9) begin
      errors++;
      $display("FAIL read_latency got=%0d expected=9 cycles from request", ack_cyc[ack_cyc.size() - 1] - t0);
    end
  endtask
  task automatic test_write();
    int t0;
    rd_val = 8'h55;
    push(1'b1, 1'b0, 1'b0);
    raise(1'b1, 1'b0, 10'h226, 8'h01, t0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.eng_ctrl !== 8'h02) begin errors++; $display("FAIL write_ctrl got=%h expected=02", bus.eng_ctrl); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.eng_wdata !== 8'h01 || bus.eng_addr !== 10'h226 || bus.eng_ctrl !== 8'h00) begin
      errors++;
      $display("FAIL write_wait wdata=%h addr=%h ctrl=%h expected 01 226 00", bus.eng_wdata, bus.eng_addr, bus.eng_ctrl);
    end
    serve(1, 40);
  endtask
  task automatic test_back_to_back();
    do_reset();
    ack_cyc.delete();
    rd_val = 8'h3C;
    push(1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    rem0 = 1;
    rem1 = 1;
    @(posedge clk);
    #1;
    bus.rw0 = 1'b1;
    bus.addr0 = 10'h2F8;
    bus.rw1 = 1'b0;
    bus.addr1 = 10'h3F8;
    bus.wdata1 = 8'hC3;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    serve(4, 120);
    for (int i = 1; i < ack_cyc.size(); i++) begin
      checks++;
      if (ack_cyc[i] - ack_cyc[i - 1] != 10) begin
        errors++;
        $display("FAIL b2b_rate idx=%0d gap=%0d expected=10", i, ack_cyc[i] - ack_cyc[i - 1]);
      end
    end
  endtask
  task automatic test_reset_mid();
    int t0;
    logic seen = 1'b0;
    rd_val = 8'h77;
    raise(1'b0, 1'b1, 10'h3A0, 8'h00, t0);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.ack0, bus.ack1, bus.eng_ctrl, bus.eng_addr, bus.rdata} !== '0) begin
      errors++;
      $display("FAIL async_reset ack=%b%b ctrl=%h addr=%h rdata=%h expected all zero",
               bus.ack1, bus.ack0, bus.eng_ctrl, bus.eng_addr, bus.rdata);
    end
    bus.req0 = 1'b0;
    q.delete();
    model_rdata = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      seen = seen | bus.ack0 | bus.ack1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_ack got ack=1 expected none"); end
    rd_val = 8'h5A;
    push(1'b0, 1'b1, 1'b0);
    raise(1'b0, 1'b1, 10'h22C, 8'h00, t0);
    serve(1, 40);
    checks++;
    if (ack_cyc[ack_cyc.size() - 1] - t0 != 9) begin
      errors++;
      $display("FAIL post_reset_latency got=%0d expected=9", ack_cyc[ack_cyc.size() - 1] - t0);
    end
  endtask
  task automatic test_late_req();
    int t0;
    int t1;
    rd_val = 8'h81;
    push(1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    raise(1'b0, 1'b1, 10'h100, 8'h00, t0);
    repeat (3) @(negedge clk);
    raise(1'b1, 1'b0, 10'h104, 8'hE7, t1);
    serve(2, 60);
    checks++;
    if (ack_cyc[ack_cyc.size() - 1] - ack_cyc[ack_cyc.size() - 2] != 10) begin
      errors++;
      $display("FAIL late_req_gap got=%0d expected=10", ack_cyc[ack_cyc.size() - 1] - ack_cyc[ack_cyc.size() - 2]);
    end
  endtask
`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    stuck = 1'b1;
    rd_val = 8'h12;
    push(1'b0, 1'b1, 1'b1);
    raise(1'b0, 1'b1, 10'h22C, 8'h00, t0);
    serve(1, 60);
    checks++;
    if (ack_cyc[ack_cyc.size() - 1] - t0 != 33) begin
      errors++;
      $display("FAIL timeout_latency got=%0d expected=33", ack_cyc[ack_cyc.size() - 1] - t0);
    end
    stuck = 1'b0;
    rd_val = 8'h99;
    push(1'b0, 1'b1, 1'b0);
    raise(1'b0, 1'b1, 10'h22C, 8'h00, t0);
    serve(1, 40);
  endtask
`endif
  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_late_req();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/isa_cycle_arbiter.md
Name: isa_cycle_arbiter

Overview:
Shares the single ISA bus-cycle engine between two requesters: port 0, the host command interface, and port 1, the status poller.
- Grants one requester at a time, round-robin on contention.
- Presents the granted address, direction and write data to the engine.
- Drives the engine's control_in read/write request bits.
- Captures read data and returns a one-cycle ack to the granted requester.
Sits directly above the bus-cycle state machine in the riser controller.

Parameters:
ADDR_W, 10, width of the ISA I/O address.
TIMEOUT, 32, max cycles in ISSUE+WAIT before abort (only with ARB_TIMEOUT_EN).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-low reset
req0 / req1  input  1  request, level; held until ack
rw0 / rw1  input  1  1=read, 0=write
addr0 / addr1  input  ADDR_W  I/O address
wdata0 / wdata1  input  8  write data
ack0 / ack1  output  1  one-cycle completion pulse
rdata  output  8  read data, valid while ackN high
err  output  1  abort flag, valid while ackN high
eng_ctrl  output  8  engine control_in; bit0=read, bit1=write, bits7:2 always 0
eng_addr  output  ADDR_W  latched address to engine address register
eng_wdata  output  8  latched write data
eng_rdata  input  8  ISA data bus from engine datapath
eng_address_load  input  1  engine address_load, active-low
eng_data_load  input  1  engine data_load, active-low
eng_control_reset  input  1  engine control_reset, active-low; marks end of cycle

Behaviour:
- Reset (async, reset=0): state=IDLE; ack0=ack1=0; eng_ctrl=0; err=0; rdata=0; eng_addr=0; eng_wdata=0; last_grant=1, so port 0 wins the first contention.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the port not equal to last_grant.
  - On grant: latch addr, wdata and rw from the granted port into eng_addr, eng_wdata and a direction flop; set eng_ctrl bit0 (read) or bit1 (write); update last_grant; go to ISSUE.
  - If no req is high: stay in IDLE, eng_ctrl=0.
- ISSUE: hold eng_ctrl until eng_address_load=0 is sampled. On that edge clear eng_ctrl to 0 and go to WAIT. The engine still sees the bit in ADDRESS_LOAD, so no re-trigger occurs.
- WAIT:
  - Read only: on any edge where eng_data_load=0, capture eng_rdata into rdata.
  - On the edge where eng_control_reset=0 is sampled: go to DONE and set ackN=1 for the granted port.
- DONE: ackN high for exactly one cycle; then ackN=0 and go to IDLE.
- rdata holds its value until the next read completes. A write leaves rdata unchanged.
- Requester rules:
  - Hold req, rw, addr and wdata stable from assertion until ack is sampled.
  - Deassert req on the edge ack is sampled.
  - The arbiter does not re-sample fields after the grant.
- Latency with the engine: ack goes high 8 cycles after the IDLE edge that grants. Back-to-back issue rate is one transaction per 10 cycles.
- Contention: alternates strictly; a port never waits more than one transaction.
- A req that rises during ISSUE, WAIT or DONE waits for IDLE.
- A req dropped illegally after grant: the transaction completes and ack still pulses.
- Reset mid-operation (any state): immediate return to reset values, no ack. The engine shares the same reset.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - An 8-bit counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT-1 without completion: eng_ctrl=0, go to DONE, ackN=1 with err=1, rdata unchanged.
  - err is cleared on the next grant.
  - A completion on the same edge as the timeout wins, so err=0.
- Undefined: no counter; err is tied to 0; the arbiter waits indefinitely.

Test Plan:
- req0 read, addr=0x22C, engine returns eng_rdata=0xAA -> eng_ctrl=0x01 for 2 cycles; eng_addr=0x22C; ack0 pulses 8 cycles after grant with rdata=0xAA, err=0.
- req1 write, addr=0x226, wdata=0x01 -> eng_ctrl=0x02; eng_wdata=0x01 held through WAIT; ack1 pulses; rdata keeps its prior value.
- req0 and req1 raised together from reset, both held, 4 transactions -> grant order 0,1,0,1; no ack overlap.
- Reset pulled low while in WAIT -> eng_ctrl=0 and ack0=ack1=0 asynchronously; after release, state=IDLE and a new req0 completes normally.
- ARB_TIMEOUT_EN defined, TIMEOUT=32, eng_control_reset stuck high -> ack0 with err=1 exactly 32 cycles after grant; the next normal read clears err.
- req1 raised while port 0 is in WAIT -> port 1 granted in the first IDLE cycle after ack0; no lost request.
